// File: rtl/uart_rx_buffer.sv
// rtl/uart_rx_buffer.sv - CPLD UART byte reader feeding a show-ahead receive FIFO
//
// Purpose:
//   Watches the CPLD byte-available flag, requests the shared ram1 data bus,
//   strobes rdn low for RD_CYCLES clocks, captures the byte on the edge that
//   ends the strobe and pushes it into a 2^DEPTH_LOG2 byte FIFO read by the CPU.
//
// Optional feature macro: UART_RX_OVF_COUNT_EN
//   Defined   : ovf_cnt counts dropped bytes, saturating at 255.
//   Undefined : ovf_cnt is tied to zero and no counter is built.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-low reset
//   data_ready in   CPLD UART byte-available flag
//   rx_data    in   [7:0] byte on the ram1 data bus while rdn is low
//   bus_gnt    in   arbiter grant of the ram1 data bus
//   pop        in   CPU read strobe, one pulse consumes one byte
//   clr_ovf    in   clears the sticky overflow flag (and counter)
//   rdn        out  CPLD read strobe, active-low
//   bus_req    out  ram1 data bus request
//   dout       out  [7:0] FIFO head byte (show-ahead)
//   rx_valid   out  FIFO not empty
//   full       out  FIFO full
//   count      out  [DEPTH_LOG2:0] bytes held
//   ovf        out  sticky overflow flag
//   ovf_cnt    out  [7:0] dropped-byte counter
module uart_rx_buffer #(
   parameter int DEPTH_LOG2 = 3,
   parameter int RD_CYCLES  = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  data_ready,
   input  logic [7:0]            rx_data,
   input  logic                  bus_gnt,
   input  logic                  pop,
   input  logic                  clr_ovf,
   output logic                  rdn,
   output logic                  bus_req,
   output logic [7:0]            dout,
   output logic                  rx_valid,
   output logic                  full,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  ovf,
   output logic [7:0]            ovf_cnt
);

   localparam int                    DEPTH     = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0]   DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
   localparam logic [DEPTH_LOG2:0]   CNT_ONE   = 1;
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = 1;
   localparam logic [3:0]            LAST_STRB = 4'(RD_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_STROBE,
      ST_WAIT
   } state_t;

   state_t                state_q, state_d;
   logic [3:0]            strb_cnt_q, strb_cnt_d;
   logic                  capture;

   logic [7:0]            mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0]   count_q, count_d;
   logic                  rx_valid_q, full_q;
   logic                  ovf_q, ovf_d;
   logic                  do_pop, do_push, drop;

   // Read FSM. rdn and bus_req decode straight from the state register so an
   // asynchronous reset releases rdn in the same instant it forces IDLE.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         strb_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         strb_cnt_q <= strb_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      strb_cnt_d = strb_cnt_q;
      rdn        = 1'b1;
      bus_req    = 1'b0;
      capture    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (data_ready) state_d = ST_REQ;
         end
         ST_REQ: begin
            bus_req = 1'b1;
            if (bus_gnt) begin
               state_d    = ST_STROBE;
               strb_cnt_d = '0;
            end
         end
         ST_STROBE: begin
            // Grant is no longer looked at: the strobe always runs to completion.
            rdn     = 1'b0;
            bus_req = 1'b1;
            if (strb_cnt_q == LAST_STRB) begin
               capture = 1'b1;
               state_d = ST_WAIT;
            end else begin
               strb_cnt_d = strb_cnt_q + 4'd1;
            end
         end
         ST_WAIT: begin
            // Hold off until the CPLD drops its flag so one byte gives one push.
            if (!data_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FIFO control. A capture into a full FIFO still lands if the CPU pops on
   // the same edge, since the pop frees the slot being written.
   always_comb begin
      do_pop   = pop && rx_valid_q;
      do_push  = capture && (!full_q || do_pop);
      drop     = capture && full_q && !pop;
      wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_d = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
      count_d  = count_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
      ovf_d = ovf_q;
      if (drop)         ovf_d = 1'b1;
      else if (clr_ovf) ovf_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         rx_valid_q <= 1'b0;
         full_q     <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         rx_valid_q <= (count_d != '0);
         full_q     <= (count_d == DEPTH_CNT);
         ovf_q      <= ovf_d;
      end
   end

   // Storage has no reset; only entries between the pointers are ever observed.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= rx_data;
   end

   assign dout     = mem_q[rd_ptr_q];
   assign rx_valid = rx_valid_q;
   assign full     = full_q;
   assign count    = count_q;
   assign ovf      = ovf_q;

`ifdef UART_RX_OVF_COUNT_EN
   logic [7:0] ovf_cnt_q, ovf_cnt_d;

   // A drop in the same cycle as a clear still counts.
   always_comb begin
      ovf_cnt_d = ovf_cnt_q;
      if (drop) begin
         if (ovf_cnt_q != 8'hFF) ovf_cnt_d = ovf_cnt_q + 8'd1;
      end else if (clr_ovf) begin
         ovf_cnt_d = 8'h00;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) ovf_cnt_q <= 8'h00;
      else      ovf_cnt_q <= ovf_cnt_d;
   end

   assign ovf_cnt = ovf_cnt_q;
`else
   assign ovf_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_uart_rx_buffer.sv
// tb/tb_uart_rx_buffer.sv - self-checking bench for uart_rx_buffer
module tb_uart_rx_buffer;

   localparam int DEPTH_LOG2 = 3;
   localparam int DEPTH      = 8;
   localparam int RD_CYCLES  = 2;
`ifdef UART_RX_OVF_COUNT_EN
   localparam int OVF_CNT_EN = 1;
`else
   localparam int OVF_CNT_EN = 0;
`endif

   logic                clk        = 1'b0;
   logic                rst        = 1'b0;
   logic                data_ready = 1'b0;
   logic [7:0]          rx_data    = 8'h00;
   logic                bus_gnt    = 1'b0;
   logic                pop        = 1'b0;
   logic                clr_ovf    = 1'b0;
   logic                rdn;
   logic                bus_req;
   logic [7:0]          dout;
   logic                rx_valid;
   logic                full;
   logic [DEPTH_LOG2:0] count;
   logic                ovf;
   logic [7:0]          ovf_cnt;

   int  n_chk   = 0;
   int  n_fail  = 0;
   bit  cmp_en  = 1'b0;
   bit  cap_exp = 1'b0;

   byte unsigned mq[$];
   bit           m_ovf     = 1'b0;
   int           m_ovf_cnt = 0;

   uart_rx_buffer #(
      .DEPTH_LOG2 (DEPTH_LOG2),
      .RD_CYCLES  (RD_CYCLES)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .data_ready (data_ready),
      .rx_data    (rx_data),
      .bus_gnt    (bus_gnt),
      .pop        (pop),
      .clr_ovf    (clr_ovf),
      .rdn        (rdn),
      .bus_req    (bus_req),
      .dout       (dout),
      .rx_valid   (rx_valid),
      .full       (full),
      .count      (count),
      .ovf        (ovf),
      .ovf_cnt    (ovf_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      mq.delete();
      m_ovf     = 1'b0;
      m_ovf_cnt = 0;
   endtask

   // Byte-level FIFO behaviour evaluated at each rising edge from the inputs
   // the bench is presenting; cap_exp marks the edge the bench expects to
   // end a strobe.
   task automatic model_update();
      bit drop;
      if (!rst) begin
         model_clear();
         return;
      end
      drop = 1'b0;
      if (pop && mq.size() != 0) void'(mq.pop_front());
      if (cap_exp) begin
         if (mq.size() < DEPTH) mq.push_back(rx_data);
         else                   drop = 1'b1;
      end
      if (drop) begin
         m_ovf = 1'b1;
         if (OVF_CNT_EN != 0 && m_ovf_cnt < 255) m_ovf_cnt++;
      end else if (clr_ovf) begin
         m_ovf     = 1'b0;
         m_ovf_cnt = 0;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (rst && cmp_en) begin
         chk("rx_valid", 32'(rx_valid), 32'(mq.size() != 0));
         chk("count",    32'(count),    32'(mq.size()));
         chk("full",     32'(full),     32'(mq.size() == DEPTH));
         chk("ovf",      32'(ovf),      32'(m_ovf));
         chk("ovf_cnt",  32'(ovf_cnt),  32'(m_ovf_cnt));
         if (mq.size() != 0) chk("dout", 32'(dout), 32'(mq[0]));
      end
   end

   task automatic chk_bus(input string name, input logic exp_rdn, input logic exp_req);
      chk({name, "_rdn"},     32'(rdn),     32'(exp_rdn));
      chk({name, "_bus_req"}, 32'(bus_req), 32'(exp_req));
   endtask

   // Raise data_ready and walk into REQ, holding the grant off for 'stall' cycles.
   task automatic begin_read(input logic [7:0] b, input int stall);
      data_ready = 1'b1;
      rx_data    = b;
      bus_gnt    = (stall == 0);
      step();
      repeat (stall) begin
         chk_bus("stall", 1'b1, 1'b1);
         step();
      end
   endtask

   // From REQ: grant, strobe for RD_CYCLES, capture, WAIT for 'hold' cycles, IDLE.
   task automatic finish_read(input bit pop_at_cap, input bit clr_at_cap, input int hold);
      bus_gnt = 1'b1;
      chk_bus("req", 1'b1, 1'b1);
      step();
      for (int k = 0; k < RD_CYCLES; k++) begin
         chk_bus("strobe", 1'b0, 1'b1);
         bus_gnt = 1'b0;
         if (k == RD_CYCLES - 1) begin
            cap_exp = 1'b1;
            pop     = pop_at_cap;
            clr_ovf = clr_at_cap;
         end
         step();
      end
      cap_exp = 1'b0;
      pop     = 1'b0;
      clr_ovf = 1'b0;
      chk_bus("wait", 1'b1, 1'b0);
      repeat (hold) begin
         step();
         chk_bus("wait_hold", 1'b1, 1'b0);
      end
      data_ready = 1'b0;
      step();
      chk_bus("idle", 1'b1, 1'b0);
   endtask

   task automatic read_byte(input logic [7:0] b, input int stall, input bit pop_at_cap,
                            input bit clr_at_cap, input int hold);
      begin_read(b, stall);
      finish_read(pop_at_cap, clr_at_cap, hold);
   endtask

   task automatic pop_one();
      pop = 1'b1;
      step();
      pop = 1'b0;
   endtask

   initial begin
      // Reset state
      rst = 1'b0;
      repeat (3) step();
      chk_bus("reset", 1'b1, 1'b0);
      chk("reset_count",    32'(count),    32'd0);
      chk("reset_rx_valid", 32'(rx_valid), 32'd0);
      chk("reset_full",     32'(full),     32'd0);
      chk("reset_ovf",      32'(ovf),      32'd0);
      chk("reset_ovf_cnt",  32'(ovf_cnt),  32'd0);
      #2 rst = 1'b1;
      cmp_en = 1'b1;
      step();

      // Single byte, WAIT held two extra cycles without a second read
      read_byte(8'h5A, 0, 1'b0, 1'b0, 2);
      chk("single_dout",  32'(dout),     32'h5A);
      chk("single_count", 32'(count),    32'd1);
      chk("single_valid", 32'(rx_valid), 32'd1);

      // Push with simultaneous pop while neither empty nor full
      read_byte(8'hA5, 0, 1'b1, 1'b0, 0);
      chk("pushpop_count", 32'(count), 32'd1);
      chk("pushpop_dout",  32'(dout),  32'hA5);
      pop_one();
      chk("pushpop_empty", 32'(count), 32'd0);

      // Grant stall
      read_byte(8'hC3, 5, 1'b0, 1'b0, 0);
      chk("stall_dout", 32'(dout), 32'hC3);
      pop_one();

      // Fill, overflow, overflow coinciding with clear
      for (int i = 0; i < 8; i++) read_byte(8'(i), 0, 1'b0, 1'b0, 0);
      chk("fill_full",  32'(full),  32'd1);
      chk("fill_count", 32'(count), 32'd8);
      chk("fill_ovf",   32'(ovf),   32'd0);
      read_byte(8'h08, 0, 1'b0, 1'b0, 0);
      chk("ovf_set",   32'(ovf),     32'd1);
      chk("ovf_cnt1",  32'(ovf_cnt), 32'(OVF_CNT_EN));
      chk("ovf_count", 32'(count),   32'd8);
      chk("ovf_head",  32'(dout),    32'h00);
      read_byte(8'h09, 0, 1'b0, 1'b1, 0);
      chk("ovf_setwins", 32'(ovf),     32'd1);
      chk("ovf_cnt2",    32'(ovf_cnt), 32'(2 * OVF_CNT_EN));
      clr_ovf = 1'b1;
      step();
      clr_ovf = 1'b0;
      chk("ovf_clr",     32'(ovf),     32'd0);
      chk("ovf_cnt_clr", 32'(ovf_cnt), 32'd0);
      for (int i = 0; i < 8; i++) begin
         chk("fill_order", 32'(dout), 32'(i));
         pop_one();
      end
      chk("drain_count", 32'(count),    32'd0);
      chk("drain_valid", 32'(rx_valid), 32'd0);

      // Full with pop at the capture edge
      for (int i = 0; i < 8; i++) read_byte(8'(8'h10 + i), 0, 1'b0, 1'b0, 0);
      read_byte(8'h18, 0, 1'b1, 1'b0, 0);
      chk("fullpop_count", 32'(count), 32'd8);
      chk("fullpop_ovf",   32'(ovf),   32'd0);
      chk("fullpop_full",  32'(full),  32'd1);
      for (int i = 0; i < 8; i++) begin
         chk("fullpop_order", 32'(dout), 32'(8'h11 + i));
         pop_one();
      end

      // Pop when empty
      pop_one();
      chk("emptypop_count", 32'(count),    32'd0);
      chk("emptypop_valid", 32'(rx_valid), 32'd0);
      read_byte(8'h33, 0, 1'b0, 1'b0, 0);
      chk("emptypop_dout",  32'(dout),  32'h33);
      chk("emptypop_count1", 32'(count), 32'd1);

      // Mid-read reset during the second strobe cycle
      data_ready = 1'b1;
      rx_data    = 8'h99;
      bus_gnt    = 1'b1;
      step();
      step();
      chk_bus("midrst_s1", 1'b0, 1'b1);
      step();
      chk_bus("midrst_s2", 1'b0, 1'b1);
      #2 rst = 1'b0;
      #1;
      chk_bus("midrst_async", 1'b1, 1'b0);
      chk("midrst_count", 32'(count),    32'd0);
      chk("midrst_valid", 32'(rx_valid), 32'd0);
      model_clear();
      bus_gnt = 1'b0;
      step();
      #2 rst = 1'b1;
      rx_data = 8'h77;
      step();
      chk_bus("midrst_req", 1'b1, 1'b1);
      finish_read(1'b0, 1'b0, 0);
      chk("midrst_dout",  32'(dout),  32'h77);
      chk("midrst_count1", 32'(count), 32'd1);
      pop_one();

      repeat (2) step();
      cmp_en = 1'b0;
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_rx_buffer.md
UART_RX_BUFFER -- requirements
Module: uart_rx_buffer

Interface
REQ-001 SHALL provide parameter DEPTH_LOG2, default 3, FIFO depth = 2^DEPTH_LOG2 bytes.
REQ-002 SHALL provide parameter RD_CYCLES, default 2, number of clk cycles rdn is held low per read (legal 1..15).
REQ-003 SHALL have ports, in order:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset; asynchronous, active-low.
- data_ready  input  1  CPLD UART byte-available flag.
- rx_data  input  8  byte driven by CPLD on the ram1 data bus while rdn is low.
- bus_gnt  input  1  arbiter grant of the ram1 data bus.
- pop  input  1  CPU read strobe; one pulse consumes one byte.
- clr_ovf  input  1  clears the overflow flag.
- rdn  output  1  CPLD read strobe, active-low.
- bus_req  output  1  request for the ram1 data bus.
- dout  output  8  FIFO head byte (show-ahead).
- rx_valid  output  1  FIFO not empty.
- full  output  1  FIFO full.
- count  output  DEPTH_LOG2+1  bytes held.
- ovf  output  1  sticky overflow flag.
- ovf_cnt  output  8  dropped-byte counter (see Configuration).

Function
REQ-004 SHALL implement a four-state read FSM: IDLE, REQ, STROBE, WAIT.
REQ-005 IDLE: when data_ready=1, go to REQ next cycle; otherwise stay.
REQ-006 REQ: bus_req=1; when bus_gnt=1, go to STROBE next cycle.
REQ-007 STROBE: rdn=0 and bus_req=1 for exactly RD_CYCLES cycles; bus_gnt is ignored once STROBE is entered.
REQ-008 SHALL sample rx_data on the clk edge that ends the last STROBE cycle, then enter WAIT; rdn=1 and bus_req=0 from that edge on.
REQ-009 WAIT: stay until data_ready=0, then go to IDLE; this guarantees one push per CPLD byte.
REQ-010 In every state other than STROBE, rdn SHALL be 1; outside REQ and STROBE, bus_req SHALL be 0.
REQ-011 Push at the capture edge when not full. When full and pop=0, the byte is dropped and ovf is set to 1.
REQ-012 If full and pop=1 at the capture edge, the push SHALL succeed: count is unchanged, the head advances, and ovf is unaffected.
REQ-013 pop=1 with rx_valid=1 SHALL advance the head at that edge. pop with rx_valid=0 SHALL be ignored with no pointer change.
REQ-014 dout SHALL equal the head entry combinationally whenever rx_valid=1; it is don't-care when empty.
REQ-015 Pointers SHALL wrap modulo 2^DEPTH_LOG2. count SHALL range 0..2^DEPTH_LOG2. full = (count == 2^DEPTH_LOG2).
REQ-016 Simultaneous push and pop when not full or empty SHALL leave count unchanged.
REQ-017 clr_ovf=1 SHALL clear ovf. If an overflow occurs in the same cycle, set wins.
REQ-018 rx_valid, full, count, and ovf SHALL be registered outputs and update on the edge of the causing event.

Reset
REQ-019 While rst=0: FSM=IDLE, rdn=1, bus_req=0, pointers=0, count=0, rx_valid=0, full=0, ovf=0, ovf_cnt=0.
REQ-020 Reset asserted during STROBE SHALL return rdn to 1 immediately (asynchronously) and discard the in-flight byte.
REQ-021 After rst deasserts with data_ready=1, the FSM SHALL enter REQ on the first clk edge.

Configuration
REQ-022 Macro UART_RX_OVF_COUNT_EN: when defined, ovf_cnt SHALL increment on each dropped byte and saturate at 255; clr_ovf also zeroes it, with increment winning on the same cycle.
REQ-023 Without UART_RX_OVF_COUNT_EN, the ovf_cnt port SHALL still exist, SHALL be tied to 0, and no counter logic SHALL be built.

Verification
REQ-024 Single byte: data_ready=1, bus_gnt held 1, rx_data=0x5A, data_ready dropped after the rdn rising edge.
- Required: rdn low exactly 2 cycles; rx_valid=1 one cycle after capture; dout=0x5A; count=1.
REQ-025 Grant stall: bus_gnt=0 for 5 cycles after REQ.
- Required: bus_req=1 and rdn=1 throughout the stall; rdn falls the cycle after bus_gnt=1.
REQ-026 Fill and overflow (depth 8): push 0x00..0x08 without pop.
- Required: full=1 after 8 bytes; 9th byte dropped; ovf=1; ovf_cnt=1 with macro, 0 without; pop order 0x00..0x07.
REQ-027 Full with pop at capture edge:
- Required: byte accepted; count stays 8; ovf stays 0; order preserved across pointer wrap.
REQ-028 Pop when empty: pop=1 with count=0.
- Required: count stays 0, rx_valid stays 0, and the next pushed byte 0x33 appears on dout.
REQ-029 Mid-read reset: rst=0 during the second STROBE cycle.
- Required: rdn=1 immediately, count=0, and the FSM re-enters REQ on the first edge after release with data_ready still 1.
